// File: rtl/eqz_scan.sv
// eqz_scan: multi-cycle zero detector and leading-zero counter.
// One CHUNK-wide slice of the operand is examined per cycle, MSB first. All
// chunks share a single priority/NOR stage, so the block trades latency for area.
//
// Ports
//   clock      rising-edge clock
//   reset      synchronous, active-high
//   in_valid   operand offered            in_ready   operand can be accepted
//   in_data    WIDTH-bit operand
//   out_valid  result available           out_ready  consumer takes the result
//   out_zero   operand was all zeros
//   out_lzc    leading zeros from bit WIDTH-1 (WIDTH when out_zero=1)
//   busy       scan in progress
//
// state | meaning
// IDLE  | waiting for an operand, in_ready=1
// SCAN  | one chunk examined per cycle, MSB chunk first
// DONE  | result held on out_* until out_ready
module eqz_scan #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_zero,
  output logic [$clog2(WIDTH+1)-1:0] out_lzc,
  output logic                       busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int LW     = $clog2(WIDTH + 1);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] scan_q, scan_nxt;
  logic [LW-1:0]    lzc_q, lzc_nxt;
  logic [IW-1:0]    idx_q, idx_nxt;
  logic             found_q, found_nxt;
  logic             zero_q, zero_nxt;
  logic [LW-1:0]    res_lzc_q, res_lzc_nxt;

  logic [CHUNK-1:0] chunk;
  logic [LW-1:0]    chunk_lz;
  logic             chunk_nz;

  // Shared chunk stage: leading zeros inside the top chunk. The loop runs
  // LSB upward so the highest set bit is the last one to win; an all-zero
  // chunk keeps the default of CHUNK.
  always_comb begin
    chunk    = scan_q[WIDTH-1 -: CHUNK];
    chunk_nz = |chunk;
    chunk_lz = LW'(CHUNK);
    for (int i = 0; i < CHUNK; i++) begin
      if (chunk[i]) chunk_lz = LW'(CHUNK - 1 - i);
    end
  end

  always_comb begin
    state_nxt   = state;
    scan_nxt    = scan_q;
    lzc_nxt     = lzc_q;
    idx_nxt     = idx_q;
    found_nxt   = found_q;
    zero_nxt    = zero_q;
    res_lzc_nxt = res_lzc_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          scan_nxt  = in_data;
          lzc_nxt   = '0;
          idx_nxt   = '0;
          found_nxt = 1'b0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        busy = 1'b1;
        // Once the first set bit has been seen the count is final; later
        // chunks (full-scan mode only) just shift through.
        if (!found_q) begin
          lzc_nxt   = lzc_q + chunk_lz;
          found_nxt = chunk_nz;
        end
        scan_nxt = scan_q << CHUNK;
        idx_nxt  = idx_q + IW'(1);
        if ((idx_q == IW'(NCHUNK - 1)) ||
            ((EARLY_EXIT != 0) && chunk_nz && !found_q)) begin
          state_nxt   = DONE;
          zero_nxt    = ~found_nxt;
          res_lzc_nxt = lzc_nxt;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      scan_q    <= '0;
      lzc_q     <= '0;
      idx_q     <= '0;
      found_q   <= 1'b0;
      zero_q    <= 1'b0;
      res_lzc_q <= '0;
    end else begin
      state     <= state_nxt;
      scan_q    <= scan_nxt;
      lzc_q     <= lzc_nxt;
      idx_q     <= idx_nxt;
      found_q   <= found_nxt;
      zero_q    <= zero_nxt;
      res_lzc_q <= res_lzc_nxt;
    end
  end

  assign out_zero = zero_q;
  assign out_lzc  = res_lzc_q;

endmodule

// File: tb/tb_eqz_scan.sv
module tb_eqz_scan;

  localparam int NCFG = 5;
  localparam int CFG_W [NCFG] = '{32, 32, 16, 16, 32};
  localparam int CFG_C [NCFG] = '{8, 8, 16, 1, 4};
  localparam int CFG_E [NCFG] = '{1, 0, 1, 1, 0};
  localparam int NRAND = 400;

  typedef struct {
    int          cfg;
    logic [31:0] data;
    int          k;
    bit          zero;
    int          lzc;
  } vec_t;

  vec_t vecs[$];
  bit   tbl_ready = 1'b0;
  int   checks    = 0;
  int   failures  = 0;
  int   done_cnt  = 0;

  logic clock = 1'b0;
  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: count zeros from the top bit down until a one is found.
  function automatic int ref_lzc(input logic [31:0] v, input int w);
    int n = 0;
    while (n < w && v[w - 1 - n] == 1'b0) n++;
    return n;
  endfunction

  function automatic void add(input int c, input logic [31:0] d, input int k, input bit z, input int l);
    vec_t v;
    v.cfg = c; v.data = d; v.k = k; v.zero = z; v.lzc = l;
    vecs.push_back(v);
  endfunction

  // ---------------- hand-sequence instance (32/8/early exit) ----------------
  logic        h_reset, h_in_valid, h_in_ready, h_out_valid, h_out_ready, h_out_zero, h_busy;
  logic [31:0] h_in_data;
  logic [5:0]  h_out_lzc;

  eqz_scan #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u_hand (
    .clock(clock), .reset(h_reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
    .in_data(h_in_data), .out_valid(h_out_valid), .out_ready(h_out_ready),
    .out_zero(h_out_zero), .out_lzc(h_out_lzc), .busy(h_busy));

  task automatic h_step();
    @(posedge clock); #1;
  endtask

  task automatic h_collect(output int n);
    n = 0;
    while (!h_out_valid && n < 40) begin h_step(); n++; end
  endtask

  initial begin
    int n, seen;
    add(0, 32'h0000_0000, 4, 1, 32);
    add(0, 32'h0001_0000, 2, 0, 15);
    add(0, 32'h8000_0000, 1, 0, 0);
    add(0, 32'h0000_0001, 4, 0, 31);
    add(1, 32'h0001_0000, 4, 0, 15);
    add(1, 32'h8000_0000, 4, 0, 0);
    add(1, 32'h0000_0000, 4, 1, 32);
    add(2, 32'h0000_0040, 1, 0, 9);
    add(2, 32'h0000_0000, 1, 1, 16);
    add(2, 32'h0000_8000, 1, 0, 0);
    add(3, 32'h0000_0000, 16, 1, 16);
    add(3, 32'h0000_0001, 16, 0, 15);
    add(3, 32'h0000_8000, 1, 0, 0);
    add(3, 32'h0000_0100, 8, 0, 7);
    add(4, 32'h0000_0F00, 8, 0, 20);
    add(4, 32'h0000_0000, 8, 1, 32);
    tbl_ready = 1'b1;

    h_reset = 1'b1; h_in_valid = 1'b0; h_out_ready = 1'b0; h_in_data = '0;
    repeat (2) h_step();
    chk("h_rst_in_ready", h_in_ready, 1);
    chk("h_rst_out_valid", h_out_valid, 0);
    chk("h_rst_out_zero", h_out_zero, 0);
    chk("h_rst_out_lzc", h_out_lzc, 0);
    chk("h_rst_busy", h_busy, 0);
    h_reset = 1'b0;

    // Operand offered while busy is held by the producer and taken later.
    h_out_ready = 1'b1; h_in_valid = 1'b1; h_in_data = 32'h8000_0000;
    h_step();
    chk("h_msb_accept_busy", h_busy, 1);
    h_in_data = 32'h0000_0100;
    h_collect(n);
    chk("h_msb_latency", n, 1);
    chk("h_msb_lzc", h_out_lzc, 0);
    chk("h_msb_zero", h_out_zero, 0);
    h_step();
    chk("h_msb_post_in_ready", h_in_ready, 1);
    chk("h_msb_post_valid", h_out_valid, 0);
    h_step();
    chk("h_held_accept_busy", h_busy, 1);
    h_in_valid = 1'b0;
    h_collect(n);
    chk("h_held_latency", n, 3);
    chk("h_held_lzc", h_out_lzc, 23);

    // Output stall: result stable, no accept while DONE.
    h_out_ready = 1'b0; h_in_valid = 1'b1; h_in_data = 32'h0000_0001;
    for (int i = 0; i < 5; i++) begin
      h_step();
      chk("h_stall_valid", h_out_valid, 1);
      chk("h_stall_zero", h_out_zero, 0);
      chk("h_stall_lzc", h_out_lzc, 23);
      chk("h_stall_in_ready", h_in_ready, 0);
      chk("h_stall_busy", h_busy, 0);
    end
    h_out_ready = 1'b1;
    h_step();
    chk("h_stall_rel_in_ready", h_in_ready, 1);
    chk("h_stall_rel_valid", h_out_valid, 0);
    chk("h_stall_rel_lzc_kept", h_out_lzc, 23);
    h_step();
    chk("h_lsb_accept_busy", h_busy, 1);
    h_in_valid = 1'b0;
    h_collect(n);
    chk("h_lsb_latency", n, 4);
    chk("h_lsb_lzc", h_out_lzc, 31);
    h_step();
    chk("h_lsb_post_valid", h_out_valid, 0);

    // Reset during the second scan cycle of a zero operand.
    h_in_valid = 1'b1; h_in_data = 32'h0;
    h_step();
    h_in_valid = 1'b0;
    h_step();
    chk("h_rscan_busy", h_busy, 1);
    h_reset = 1'b1;
    h_step();
    h_reset = 1'b0;
    chk("h_rscan_busy_after", h_busy, 0);
    chk("h_rscan_in_ready", h_in_ready, 1);
    chk("h_rscan_valid", h_out_valid, 0);
    chk("h_rscan_lzc", h_out_lzc, 0);
    chk("h_rscan_zero", h_out_zero, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin h_step(); if (h_out_valid || h_busy) seen++; end
    chk("h_rscan_no_stale", seen, 0);

    // Reset together with in_valid: no accept.
    h_reset = 1'b1; h_in_valid = 1'b1; h_in_data = 32'h0000_0001;
    h_step();
    h_reset = 1'b0; h_in_valid = 1'b0;
    chk("h_rst_valid_busy", h_busy, 0);
    h_step();
    chk("h_rst_valid_busy2", h_busy, 0);

    n = 0;
    while (done_cnt < NCFG && n < 90000) begin @(posedge clock); n++; end
    chk("all_configs_done", done_cnt, NCFG);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- table + random, one instance per configuration ----------------
  for (genvar g = 0; g < NCFG; g++) begin : cfg
    localparam int W   = CFG_W[g];
    localparam int C   = CFG_C[g];
    localparam int E   = CFG_E[g];
    localparam int NCH = W / C;
    localparam int LW  = $clog2(W + 1);

    logic          rst, iv, ir, ov, orr, oz, bz;
    logic [W-1:0]  id;
    logic [LW-1:0] ol;

    eqz_scan #(.WIDTH(W), .CHUNK(C), .EARLY_EXIT(E)) u_dut (
      .clock(clock), .reset(rst), .in_valid(iv), .in_ready(ir), .in_data(id),
      .out_valid(ov), .out_ready(orr), .out_zero(oz), .out_lzc(ol), .busy(bz));

    task automatic run_op(input logic [W-1:0] d, input bit stall, input int ek,
                          input bit ez, input int el, input string tag);
      int  n, guard;
      bit  hs;
      iv = 1'b0;
      if (stall) repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
      iv = 1'b1; id = d;
      guard = 0;
      while (!ir && guard < 8) begin @(posedge clock); #1; guard++; end
      @(posedge clock); #1;
      chk({tag, "_accept"}, bz, 1);
      iv = stall ? 1'($urandom) : 1'b0;
      id = W'($urandom);
      n = 0;
      while (!ov && n < W + 4) begin
        orr = stall ? 1'($urandom) : 1'b1;
        @(posedge clock); #1; n++;
        if (stall) begin iv = 1'($urandom); id = W'($urandom); end
      end
      chk({tag, "_latency"}, n, ek);
      chk({tag, "_zero"}, oz, ez);
      chk({tag, "_lzc"}, ol, el);
      guard = 0; hs = 1'b0;
      while (!hs && guard < 12) begin
        orr = (!stall || guard == 11) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
        @(posedge clock); #1; guard++;
        hs = orr;
        if (!hs) begin
          chk({tag, "_hold_valid"}, ov, 1);
          chk({tag, "_hold_zero"}, oz, ez);
          chk({tag, "_hold_lzc"}, ol, el);
          chk({tag, "_hold_in_ready"}, ir, 0);
        end
      end
      iv = 1'b0; orr = 1'b0;
      chk({tag, "_post_in_ready"}, ir, 1);
      chk({tag, "_post_valid"}, ov, 0);
      chk({tag, "_post_lzc"}, ol, el);
    endtask

    initial begin
      logic [31:0] r;
      logic [W-1:0] v;
      int sh, lz, k;
      rst = 1'b1; iv = 1'b0; orr = 1'b0; id = '0;
      repeat (2) begin @(posedge clock); #1; end
      chk($sformatf("c%0d_rst_in_ready", g), ir, 1);
      chk($sformatf("c%0d_rst_valid", g), ov, 0);
      chk($sformatf("c%0d_rst_lzc", g), ol, 0);
      chk($sformatf("c%0d_rst_busy", g), bz, 0);
      rst = 1'b0;
      wait (tbl_ready);
      foreach (vecs[i]) begin
        if (vecs[i].cfg == g)
          run_op(W'(vecs[i].data), 1'b0, vecs[i].k, vecs[i].zero, vecs[i].lzc,
                 $sformatf("c%0d_vec%0d", g, i));
      end
      for (int j = 0; j < NRAND; j++) begin
        r  = $urandom;
        sh = $urandom_range(0, W);
        v  = W'(r) >> sh;
        lz = ref_lzc(32'(v), W);
        k  = (v == '0 || E == 0) ? NCH : 1 + lz / C;
        run_op(v, 1'b1, k, v == '0, lz, $sformatf("c%0d_rnd%0d", g, j));
      end
      done_cnt++;
    end
  end

endmodule
